// File: rtl/store_pack_if.sv
// Execute-stage / data-memory bundle for store_pack_unit.
// The misalign signal exists only when STORE_MISALIGN_EXC_EN is defined.
interface store_pack_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        st_op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata_in;
  logic              busy;
  logic              done;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
`ifdef STORE_MISALIGN_EXC_EN
  logic              misalign;

  modport slave (
    input  start, st_op, addr, wdata_in, mem_ack,
    output busy, done, mem_req, mem_addr, mem_wdata, mem_be, misalign
  );
  modport master (
    output start, st_op, addr, wdata_in, mem_ack,
    input  busy, done, mem_req, mem_addr, mem_wdata, mem_be, misalign
  );
`else
  modport slave (
    input  start, st_op, addr, wdata_in, mem_ack,
    output busy, done, mem_req, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output start, st_op, addr, wdata_in, mem_ack,
    input  busy, done, mem_req, mem_addr, mem_wdata, mem_be
  );
`endif
endinterface

// File: rtl/store_pack_unit.sv
// Store-side narrowing/lane steering with a req/ack handshake to data memory.
// Optional macro STORE_MISALIGN_EXC_EN: flag misaligned SH/SW instead of storing.
module store_pack_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  store_pack_if.slave  sp
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [3:0]        be_p0;
  logic              take;
  logic              illegal;
  logic              mis;

  function automatic logic [DATA_W-1:0] pack_data(input logic [1:0] op,
                                                  input logic [DATA_W-1:0] d);
    case (op)
      2'b00:   return {(DATA_W/8){d[7:0]}};
      2'b01:   return {(DATA_W/16){d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] pack_be(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  assign take    = (state == IDLE) && sp.start;
  assign illegal = (sp.st_op == 2'b11);

`ifdef STORE_MISALIGN_EXC_EN
  logic mis_p0;
  assign mis = ((sp.st_op == 2'b01) && sp.addr[0]) ||
               ((sp.st_op == 2'b10) && (sp.addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mis_p0 <= 1'b0;
    else if (take) mis_p0 <= mis;
  end

  assign sp.misalign = (state == DONE) && mis_p0;
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sp.start) state_nxt = (illegal || mis) ? DONE : REQ;
      REQ:  if (sp.mem_ack) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operands captured at start; address word-aligned, data replicated into lanes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0 <= '0;
      data_p0 <= '0;
      be_p0   <= 4'b0000;
    end else if (take) begin
      addr_p0 <= {sp.addr[ADDR_W-1:2], 2'b00};
      data_p0 <= pack_data(sp.st_op, sp.wdata_in);
      be_p0   <= (illegal || mis) ? 4'b0000 : pack_be(sp.st_op, sp.addr[1:0]);
    end
  end

  assign sp.busy      = (state != IDLE);
  assign sp.done      = (state == DONE);
  assign sp.mem_req   = (state == REQ);
  assign sp.mem_addr  = addr_p0;
  assign sp.mem_wdata = data_p0;
  assign sp.mem_be    = (state == REQ) ? be_p0 : 4'b0000;

endmodule

// File: tb/tb_store_pack_unit.sv
// Directed bench for store_pack_unit: packing, handshake timing and corner cases.
module tb_store_pack_unit;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  store_pack_if #(.ADDR_W(32), .DATA_W(32)) sp();
  store_pack_unit #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .sp(sp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    sp.start = 1'b1; sp.st_op = op; sp.addr = a; sp.wdata_in = d;
    tick;
    sp.start = 1'b0;
  endtask

  task automatic test_reset;
    tick; tick;
    tests++; if (sp.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", sp.busy); end
    tests++; if (sp.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", sp.done); end
    tests++; if (sp.mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", sp.mem_req); end
    tests++; if (sp.mem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", sp.mem_addr); end
    tests++; if (sp.mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: got %h want 0", sp.mem_wdata); end
    tests++; if (sp.mem_be !== 4'b0000) begin fails++; $display("FAIL rst_be: got %b want 0000", sp.mem_be); end
`ifdef STORE_MISALIGN_EXC_EN
    tests++; if (sp.misalign !== 1'b0) begin fails++; $display("FAIL rst_mis: got %b want 0", sp.misalign); end
`endif
    rst = 1'b0;
    tick;
    tests++; if (sp.busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy: got %b want 0", sp.busy); end
  endtask

  task automatic test_sw;
    issue(2'b10, 32'h0000_0010, 32'hDEAD_BEEF);
    tests++; if (sp.mem_req !== 1'b1) begin fails++; $display("FAIL sw_req: got %b want 1", sp.mem_req); end
    tests++; if (sp.busy !== 1'b1) begin fails++; $display("FAIL sw_busy: got %b want 1", sp.busy); end
    tests++; if (sp.mem_addr !== 32'h10) begin fails++; $display("FAIL sw_addr: got %h want 00000010", sp.mem_addr); end
    tests++; if (sp.mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_wdata: got %h want deadbeef", sp.mem_wdata); end
    tests++; if (sp.mem_be !== 4'b1111) begin fails++; $display("FAIL sw_be: got %b want 1111", sp.mem_be); end
    sp.mem_ack = 1'b1;
    tick;
    sp.mem_ack = 1'b0;
    tests++; if (sp.done !== 1'b1) begin fails++; $display("FAIL sw_done: got %b want 1", sp.done); end
    tests++; if (sp.mem_req !== 1'b0) begin fails++; $display("FAIL sw_req_drop: got %b want 0", sp.mem_req); end
    tests++; if (sp.mem_be !== 4'b0000) begin fails++; $display("FAIL sw_be_drop: got %b want 0000", sp.mem_be); end
    tick;
    tests++; if (sp.done !== 1'b0) begin fails++; $display("FAIL sw_done_pulse: got %b want 0", sp.done); end
    tests++; if (sp.busy !== 1'b0) begin fails++; $display("FAIL sw_busy_end: got %b want 0", sp.busy); end
    tests++; if (sp.mem_addr !== 32'h10) begin fails++; $display("FAIL sw_addr_hold: got %h want 00000010", sp.mem_addr); end
  endtask

  task automatic test_sb;
    logic [31:0] a_tab  [5];
    logic [31:0] ma_tab [5];
    logic [3:0]  be_tab [5];
    a_tab  = '{32'h3, 32'h0, 32'h1, 32'h2, 32'hFFFF_FFFF};
    ma_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC};
    be_tab = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      issue(2'b00, a_tab[i], 32'h0000_00A5);
      tests++; if (sp.mem_addr !== ma_tab[i]) begin fails++; $display("FAIL sb_addr[%0d]: got %h want %h", i, sp.mem_addr, ma_tab[i]); end
      tests++; if (sp.mem_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wdata[%0d]: got %h want a5a5a5a5", i, sp.mem_wdata); end
      tests++; if (sp.mem_be !== be_tab[i]) begin fails++; $display("FAIL sb_be[%0d]: got %b want %b", i, sp.mem_be, be_tab[i]); end
      sp.mem_ack = 1'b1;
      tick;
      sp.mem_ack = 1'b0;
      tests++; if (sp.done !== 1'b1) begin fails++; $display("FAIL sb_done[%0d]: got %b want 1", i, sp.done); end
      tick;
    end
  endtask

  task automatic test_sh_wait;
    issue(2'b01, 32'h0000_0006, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      tests++; if (sp.mem_req !== 1'b1) begin fails++; $display("FAIL sh_req[%0d]: got %b want 1", i, sp.mem_req); end
      tests++; if (sp.mem_addr !== 32'h4) begin fails++; $display("FAIL sh_addr[%0d]: got %h want 00000004", i, sp.mem_addr); end
      tests++; if (sp.mem_wdata !== 32'h5678_5678) begin fails++; $display("FAIL sh_wdata[%0d]: got %h want 56785678", i, sp.mem_wdata); end
      tests++; if (sp.mem_be !== 4'b1100) begin fails++; $display("FAIL sh_be[%0d]: got %b want 1100", i, sp.mem_be); end
      if (i == 4) sp.mem_ack = 1'b1;
      tick;
    end
    sp.mem_ack = 1'b0;
    tests++; if (sp.done !== 1'b1) begin fails++; $display("FAIL sh_done: got %b want 1", sp.done); end
    tick;
  endtask

  task automatic test_busy_ignore;
    int req_cnt;
    int done_cnt;
    req_cnt  = 0;
    done_cnt = 0;
    issue(2'b10, 32'h0000_0020, 32'h1111_1111);
    if (sp.mem_req === 1'b1) req_cnt++;
    sp.start = 1'b1; sp.st_op = 2'b00; sp.addr = 32'h33; sp.wdata_in = 32'hFF;
    sp.mem_ack = 1'b1;
    tick;
    sp.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (sp.done === 1'b1) done_cnt++;
      if (sp.mem_req === 1'b1) req_cnt++;
      tick;
    end
    sp.mem_ack = 1'b0;
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); end
    tests++; if (req_cnt !== 1) begin fails++; $display("FAIL busy_req_cnt: got %0d want 1", req_cnt); end
    tests++; if (sp.mem_wdata !== 32'h1111_1111) begin fails++; $display("FAIL busy_wdata: got %h want 11111111", sp.mem_wdata); end
    tests++; if (sp.busy !== 1'b0) begin fails++; $display("FAIL busy_idle: got %b want 0", sp.busy); end
  endtask

  task automatic test_async_reset;
    issue(2'b10, 32'h0000_0040, 32'hCAFE_F00D);
    tick;
    tests++; if (sp.mem_req !== 1'b1) begin fails++; $display("FAIL arst_req_pre: got %b want 1", sp.mem_req); end
    #2 rst = 1'b1;
    #1;
    tests++; if (sp.mem_req !== 1'b0) begin fails++; $display("FAIL arst_req: got %b want 0", sp.mem_req); end
    tests++; if (sp.busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b want 0", sp.busy); end
    #1 rst = 1'b0;
    tick;
    tests++; if (sp.done !== 1'b0) begin fails++; $display("FAIL arst_done: got %b want 0", sp.done); end
    issue(2'b00, 32'h0000_0041, 32'h0000_005A);
    tests++; if (sp.mem_req !== 1'b1) begin fails++; $display("FAIL arst_next_req: got %b want 1", sp.mem_req); end
    tests++; if (sp.mem_addr !== 32'h40) begin fails++; $display("FAIL arst_next_addr: got %h want 00000040", sp.mem_addr); end
    tests++; if (sp.mem_wdata !== 32'h5A5A_5A5A) begin fails++; $display("FAIL arst_next_wdata: got %h want 5a5a5a5a", sp.mem_wdata); end
    tests++; if (sp.mem_be !== 4'b0010) begin fails++; $display("FAIL arst_next_be: got %b want 0010", sp.mem_be); end
    sp.mem_ack = 1'b1;
    tick;
    sp.mem_ack = 1'b0;
    tests++; if (sp.done !== 1'b1) begin fails++; $display("FAIL arst_next_done: got %b want 1", sp.done); end
    tick;
  endtask

  task automatic test_illegal;
    issue(2'b11, 32'h0000_0008, 32'h0000_0077);
    tests++; if (sp.mem_req !== 1'b0) begin fails++; $display("FAIL ill_req: got %b want 0", sp.mem_req); end
    tests++; if (sp.done !== 1'b1) begin fails++; $display("FAIL ill_done: got %b want 1", sp.done); end
    tests++; if (sp.mem_be !== 4'b0000) begin fails++; $display("FAIL ill_be: got %b want 0000", sp.mem_be); end
`ifdef STORE_MISALIGN_EXC_EN
    tests++; if (sp.misalign !== 1'b0) begin fails++; $display("FAIL ill_mis: got %b want 0", sp.misalign); end
`endif
    tick;
    tests++; if (sp.busy !== 1'b0) begin fails++; $display("FAIL ill_busy: got %b want 0", sp.busy); end
  endtask

  task automatic test_misalign;
    issue(2'b10, 32'h0000_0002, 32'h1357_9BDF);
`ifdef STORE_MISALIGN_EXC_EN
    tests++; if (sp.mem_req !== 1'b0) begin fails++; $display("FAIL mis_req: got %b want 0", sp.mem_req); end
    tests++; if (sp.done !== 1'b1) begin fails++; $display("FAIL mis_done: got %b want 1", sp.done); end
    tests++; if (sp.misalign !== 1'b1) begin fails++; $display("FAIL mis_flag: got %b want 1", sp.misalign); end
    tests++; if (sp.mem_be !== 4'b0000) begin fails++; $display("FAIL mis_be: got %b want 0000", sp.mem_be); end
    tick;
    tests++; if (sp.misalign !== 1'b0) begin fails++; $display("FAIL mis_flag_clear: got %b want 0", sp.misalign); end
    tests++; if (sp.done !== 1'b0) begin fails++; $display("FAIL mis_done_clear: got %b want 0", sp.done); end
`else
    tests++; if (sp.mem_req !== 1'b1) begin fails++; $display("FAIL mis_req: got %b want 1", sp.mem_req); end
    tests++; if (sp.mem_addr !== 32'h0) begin fails++; $display("FAIL mis_addr: got %h want 00000000", sp.mem_addr); end
    tests++; if (sp.mem_be !== 4'b1111) begin fails++; $display("FAIL mis_be: got %b want 1111", sp.mem_be); end
    tests++; if (sp.mem_wdata !== 32'h1357_9BDF) begin fails++; $display("FAIL mis_wdata: got %h want 13579bdf", sp.mem_wdata); end
    sp.mem_ack = 1'b1;
    tick;
    sp.mem_ack = 1'b0;
    tests++; if (sp.done !== 1'b1) begin fails++; $display("FAIL mis_done: got %b want 1", sp.done); end
    tick;
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    sp.start = 1'b0; sp.st_op = 2'b00; sp.addr = '0; sp.wdata_in = '0; sp.mem_ack = 1'b0;
    test_reset;
    test_sw;
    test_sb;
    test_sh_wait;
    test_busy_ignore;
    test_async_reset;
    test_illegal;
    test_misalign;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
